forest_sample_driver: RTL
=========================

Name: forest_sample_driver

Overview:
- Initiator side of the tree start/done/label protocol.
- Collects one wine sample as a serial stream of 11 fixed-point features and presents them in parallel to NUM_TREES tree classifiers.
- Clears the trees, pulses them through a traversal, waits for every done (or times out), then majority-votes the labels.
- Returns the result on a valid/ready interface. Sits between the sample source (UART/host loader) and the tree instances.

Parameters:
- NUM_TREES, 3, number of tree classifiers driven (1..7).
- NUM_FEAT, 11, features per sample; stream index 0 = alcohol … 10 = fixed acidity.
- FEAT_W, 16, signed feature width (Q8.8).
- TREE_DEPTH, 3, value driven on tree_depth.
- TIMEOUT, 15, max RUN cycles before giving up (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (one clock; reset is async active-low)
- feat_valid  in  1  feature beat valid
- feat_ready  out  1  driver accepts beat
- feat_data  in  FEAT_W  feature value
- feat_last  in  1  marks final beat of sample
- frame_err  out  1  one-cycle pulse: malformed sample dropped
- feat_bus  out  NUM_FEAT*FEAT_W  parallel features; slice i = stream index i
- tree_rst_n  out  1  active-low clear to all trees
- tree_start  out  1  start_traversal to all trees
- tree_depth  out  4  constant TREE_DEPTH
- tree_done  in  NUM_TREES  per-tree done
- tree_label  in  NUM_TREES  per-tree label
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_label  out  1  majority label
- res_votes  out  3  count of done trees with label 1
- res_timeout  out  1  result produced by timeout

Behaviour:
- Reset (reset=0, async): state LOAD, feature index 0, feat_bus 0, tree_rst_n 0, tree_start 0, res_valid/res_label/res_votes/res_timeout 0, frame_err 0, feat_ready 0. All outputs registered. Reset mid-operation aborts the sample entirely.
- States: LOAD → CLEAR → RUN → RESULT → LOAD.
- LOAD: feat_ready=1, tree_rst_n=1, tree_start=0.
  - On feat_valid&feat_ready: write feat_data into slice idx, idx++.
  - feat_last on idx<NUM_FEAT-1, or feat_last=0 on idx=NUM_FEAT-1: beat discarded, idx←0, frame_err=1 next cycle, remain LOAD.
  - Valid final beat: idx←0, go CLEAR; feat_ready falls the next cycle.
- CLEAR: exactly 1 cycle. tree_rst_n=0, tree_start=0, RUN cycle counter←0.
- RUN: tree_rst_n=1, tree_start=1, counter increments each cycle.
  - Cycle where tree_done is all ones → next edge RESULT with res_timeout=0.
  - Else counter==TIMEOUT → RESULT with res_timeout=1.
  - Both true in the same cycle: done wins, res_timeout=0.
  - tree_start drops to 0 on entering RESULT.
- Vote (in the deciding RUN cycle): res_votes = popcount(tree_done & tree_label); res_label = (2*res_votes > NUM_TREES). Ties → 0. On timeout, not-done trees count as 0.
- RESULT: res_valid=1; res_label/res_votes/res_timeout held stable until res_valid&res_ready. Handshake cycle → LOAD, res_valid=0 next cycle. feat_ready=0 throughout CLEAR/RUN/RESULT.
- feat_bus changes only in LOAD, so it is stable from CLEAR through RESULT.
- tree_done/tree_label are ignored outside RUN.
- Latency: final beat accepted at edge E → tree_rst_n low over [E,E+1) → tree_start high from E+1. With trees done D cycles after start, res_valid rises at E+1+D+1.

Decomposition:
- Package forest_pkg:
  - state enum {LOAD, CLEAR, RUN, RESULT}
  - FEAT_W, NUM_FEAT
  - named feature-index constants FEAT_ALCOHOL=0, FEAT_SULPHATES=1, FEAT_PH=2 … FEAT_FIXED_ACIDITY=10
- One sub-module: forest_vote (combinational popcount of done&label plus majority compare), reused by future ensemble blocks.

Test Plan:
- Stream 0x0100..0x010A, no gaps, tree models done 5 cycles after start with labels 1,1,0 → feat_bus slice i = 0x0100+i; tree_rst_n low exactly 1 cycle; res_valid 7 cycles after final beat; res_votes=2, res_label=1, res_timeout=0.
- Labels 0,1,0 with feat_valid gaps every other cycle → all 11 beats captured in order; res_votes=1, res_label=0.
- Tree 2 never asserts done, trees 0,1 label 1, TIMEOUT=15 → res_valid 16 cycles after RUN entry; res_timeout=1, res_votes=2, res_label=1. Same setup with tree 2 done at counter==TIMEOUT → res_timeout=0.
- feat_last on beat 5 → frame_err one-cycle pulse, no tree_rst_n or tree_start activity; next clean 11-beat sample gives a correct result.
- res_ready held low 10 cycles in RESULT → outputs stable, feat_ready=0; on handshake, res_valid=0 and feat_ready=1 next cycle.
- Assert reset during RUN → all outputs at reset values immediately (async); after release, a full sample completes correctly.

Source files
------------

// File: rtl/forest_pkg.sv
// rtl/forest_pkg.sv - shared types and constants for the forest ensemble blocks
package forest_pkg;

  localparam int FEAT_W   = 16;
  localparam int NUM_FEAT = 11;

  localparam int FEAT_ALCOHOL          = 0;
  localparam int FEAT_SULPHATES        = 1;
  localparam int FEAT_PH               = 2;
  localparam int FEAT_TOTAL_SULFUR     = 3;
  localparam int FEAT_DENSITY          = 4;
  localparam int FEAT_CHLORIDES        = 5;
  localparam int FEAT_VOLATILE_ACIDITY = 6;
  localparam int FEAT_FREE_SULFUR      = 7;
  localparam int FEAT_CITRIC_ACID      = 8;
  localparam int FEAT_RESIDUAL_SUGAR   = 9;
  localparam int FEAT_FIXED_ACIDITY    = 10;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    CLEAR  = 2'd1,
    RUN    = 2'd2,
    RESULT = 2'd3
  } state_t;

endpackage

// File: rtl/forest_vote.sv
// rtl/forest_vote.sv - popcount of finished trees voting 1, plus strict-majority compare
module forest_vote #(
  parameter int NUM_TREES = 3
) (
  input  logic [NUM_TREES-1:0] done,
  input  logic [NUM_TREES-1:0] label,
  output logic [2:0]           votes,
  output logic                 majority
);

  always_comb begin
    votes = 3'd0;
    for (int i = 0; i < NUM_TREES; i++) begin
      votes = votes + 3'(done[i] & label[i]);
    end
    // Ties resolve to 0: a strict majority of all trees is required.
    majority = ({1'b0, votes, 1'b0} > 5'(NUM_TREES));
  end

endmodule

// File: rtl/forest_sample_driver.sv
// rtl/forest_sample_driver.sv - loads one feature sample, runs the trees, votes and returns the label
module forest_sample_driver #(
  parameter int NUM_TREES  = 3,
  parameter int NUM_FEAT   = forest_pkg::NUM_FEAT,
  parameter int FEAT_W     = forest_pkg::FEAT_W,
  parameter int TREE_DEPTH = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       feat_valid,
  output logic                       feat_ready,
  input  logic [FEAT_W-1:0]          feat_data,
  input  logic                       feat_last,
  output logic                       frame_err,
  output logic [NUM_FEAT*FEAT_W-1:0] feat_bus,
  output logic                       tree_rst_n,
  output logic                       tree_start,
  output logic [3:0]                 tree_depth,
  input  logic [NUM_TREES-1:0]       tree_done,
  input  logic [NUM_TREES-1:0]       tree_label,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       res_label,
  output logic [2:0]                 res_votes,
  output logic                       res_timeout
);
  import forest_pkg::state_t;
  import forest_pkg::LOAD;
  import forest_pkg::CLEAR;
  import forest_pkg::RUN;
  import forest_pkg::RESULT;

  localparam int IW = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         state, state_nx;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  cnt;
  logic           accept, bad_beat, all_done, timed_out;
  logic [2:0]     votes;
  logic           majority;

  forest_vote #(.NUM_TREES(NUM_TREES)) u_vote (
    .done     (tree_done),
    .label    (tree_label),
    .votes    (votes),
    .majority (majority)
  );

  assign tree_depth = 4'(TREE_DEPTH);
  assign accept     = (state == LOAD) && feat_valid && feat_ready;
  assign bad_beat   = feat_last != (idx == IW'(NUM_FEAT - 1));
  assign all_done   = &tree_done;
  assign timed_out  = (cnt == CW'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (accept && !bad_beat && feat_last) state_nx = CLEAR;
      CLEAR:   state_nx = RUN;
      RUN:     if (all_done || timed_out) state_nx = RESULT;
      RESULT:  if (res_valid && res_ready) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      feat_ready  <= 1'b0;
      tree_rst_n  <= 1'b0;
      tree_start  <= 1'b0;
      res_valid   <= 1'b0;
      res_label   <= 1'b0;
      res_votes   <= 3'd0;
      res_timeout <= 1'b0;
      frame_err   <= 1'b0;
      feat_bus    <= '0;
      idx         <= '0;
      cnt         <= '0;
    end else begin
      feat_ready <= (state_nx == LOAD);
      tree_rst_n <= (state_nx != CLEAR);
      tree_start <= (state_nx == RUN);
      res_valid  <= (state_nx == RESULT);
      frame_err  <= accept && bad_beat;

      if (accept) begin
        if (bad_beat) begin
          idx <= '0;
        end else begin
          feat_bus[idx*FEAT_W +: FEAT_W] <= feat_data;
          idx <= feat_last ? '0 : idx + 1'b1;
        end
      end

      if (state == CLEAR) cnt <= '0;
      else if (state == RUN) cnt <= cnt + 1'b1;

      // Done beats timeout when both land in the same cycle.
      if (state == RUN && (all_done || timed_out)) begin
        res_votes   <= votes;
        res_label   <= majority;
        res_timeout <= !all_done;
      end
    end
  end

endmodule
